// File: rtl/lab2_proc_alu_arb_pkg.sv
// Shared definitions for the ALU arbiter: function encodings and message layouts.
package lab2_proc_alu_arb_pkg;

    localparam int unsigned AluDw = 32;

    localparam logic [3:0] ALU_ADD  = 4'd0;
    localparam logic [3:0] ALU_SUB  = 4'd1;
    localparam logic [3:0] ALU_AND  = 4'd2;
    localparam logic [3:0] ALU_OR   = 4'd3;
    localparam logic [3:0] ALU_XOR  = 4'd4;
    localparam logic [3:0] ALU_SLT  = 4'd5;
    localparam logic [3:0] ALU_SLTU = 4'd6;
    localparam logic [3:0] ALU_SRA  = 4'd7;
    localparam logic [3:0] ALU_SRL  = 4'd8;
    localparam logic [3:0] ALU_SLL  = 4'd9;
    localparam logic [3:0] ALU_CP0  = 4'd11;
    localparam logic [3:0] ALU_CP1  = 4'd12;

    // Request layout: fn [67:64], in0 [63:32], in1 [31:0]
    typedef struct packed {
        logic [3:0]       fn;
        logic [AluDw-1:0] in0;
        logic [AluDw-1:0] in1;
    } alu_req_msg_t;

    // Response layout: out [34:3], eq [2], lt [1], ltu [0]
    typedef struct packed {
        logic [AluDw-1:0] out;
        logic             eq;
        logic             lt;
        logic             ltu;
    } alu_resp_msg_t;

endpackage

// File: rtl/lab2_proc_alu_core.sv
// Combinational ALU with comparison flags; flags are produced for every fn.
module lab2_proc_alu_core
    import lab2_proc_alu_arb_pkg::*;
#(
    parameter int unsigned DW = AluDw
) (
    input  logic [3:0]    fn,
    input  logic [DW-1:0] in0,
    input  logic [DW-1:0] in1,
    output logic [DW-1:0] out,
    output logic          eq,
    output logic          lt,
    output logic          ltu
);

    logic [4:0] shamt;
    assign shamt = in1[4:0];

    // Evaluate the selected function and the three compare flags.
    always_comb begin
        eq  = (in0 == in1);
        lt  = ($signed(in0) < $signed(in1));
        ltu = (in0 < in1);
        out = '0;
        case (fn)
            ALU_ADD:  out = in0 + in1;
            ALU_SUB:  out = in0 - in1;
            ALU_AND:  out = in0 & in1;
            ALU_OR:   out = in0 | in1;
            ALU_XOR:  out = in0 ^ in1;
            ALU_SLT:  out = {{(DW-1){1'b0}}, lt};
            ALU_SLTU: out = {{(DW-1){1'b0}}, ltu};
            ALU_SRA:  out = $signed(in0) >>> shamt;
            ALU_SRL:  out = in0 >> shamt;
            ALU_SLL:  out = in0 << shamt;
            ALU_CP0:  out = in0;
            ALU_CP1:  out = in1;
            default:  out = '0;
        endcase
    end

endmodule

// File: rtl/lab2_proc_alu_arbiter.sv
// Two-requester arbiter in front of a single shared ALU, with a one-entry
// output register routed back to the granted requester.
// Build option: define LAB2_PROC_ALU_ARB_FIXED_PRIO_EN to make requester 0
// always win ties (no round-robin pointer; requester 1 can starve).
module lab2_proc_alu_arbiter
    import lab2_proc_alu_arb_pkg::*;
#(
    parameter int unsigned NREQ = 2,
    parameter int unsigned DW   = 32
) (
    input  logic            clk,
    input  logic            reset,

    input  logic            req0_val,
    output logic            req0_rdy,
    input  logic [2*DW+3:0] req0_msg,
    input  logic            req1_val,
    output logic            req1_rdy,
    input  logic [2*DW+3:0] req1_msg,

    output logic            resp0_val,
    input  logic            resp0_rdy,
    output logic [DW+2:0]   resp0_msg,
    output logic            resp1_val,
    input  logic            resp1_rdy,
    output logic [DW+2:0]   resp1_msg
);

    localparam int unsigned OwnerW = $clog2(NREQ);

    logic              r_val_q, r_val_d;
    logic [OwnerW-1:0] r_owner_q, r_owner_d;
    alu_resp_msg_t     r_msg_q, r_msg_d;

    logic              free;
    logic              drain;
    logic              fire;
    logic [OwnerW-1:0] win;
    alu_req_msg_t      sel_msg;
    alu_resp_msg_t     alu_resp;

`ifndef LAB2_PROC_ALU_ARB_FIXED_PRIO_EN
    logic [OwnerW-1:0] prio_q, prio_d;
`endif

    // The register can accept a new result if empty or being drained now.
    assign drain = r_val_q && ((r_owner_q == '0) ? resp0_rdy : resp1_rdy);
    assign free  = !r_val_q || drain;

    // Pick the winner: tie goes to the priority pointer (or requester 0).
    always_comb begin
        win = '0;
        if (req0_val && req1_val) begin
`ifdef LAB2_PROC_ALU_ARB_FIXED_PRIO_EN
            win = '0;
`else
            win = prio_q;
`endif
        end else if (req1_val) begin
            win = 1'b1;
        end
    end

    // Rdy depends only on vals, resp rdys and state, never on request payloads.
    assign req0_rdy = !reset && req0_val && (win == '0) && free;
    assign req1_rdy = !reset && req1_val && (win != '0) && free;
    assign fire     = req0_rdy || req1_rdy;

    assign sel_msg = (win != '0) ? alu_req_msg_t'(req1_msg) : alu_req_msg_t'(req0_msg);

    lab2_proc_alu_core #(
        .DW (DW)
    ) u_alu_core (
        .fn  (sel_msg.fn),
        .in0 (sel_msg.in0),
        .in1 (sel_msg.in1),
        .out (alu_resp.out),
        .eq  (alu_resp.eq),
        .lt  (alu_resp.lt),
        .ltu (alu_resp.ltu)
    );

    // Next state of the output register: reload on fire, empty on a bare drain.
    always_comb begin
        r_val_d   = r_val_q;
        r_owner_d = r_owner_q;
        r_msg_d   = r_msg_q;
        if (fire) begin
            r_val_d   = 1'b1;
            r_owner_d = win;
            r_msg_d   = alu_resp;
        end else if (drain) begin
            r_val_d = 1'b0;
        end
    end

`ifndef LAB2_PROC_ALU_ARB_FIXED_PRIO_EN
    // After a fire the other requester gets the next tie.
    always_comb begin
        prio_d = prio_q;
        if (fire) begin
            prio_d = (win == '0) ? 1'b1 : 1'b0;
        end
    end

    // Round-robin pointer register.
    always_ff @(posedge clk) begin
        if (reset) begin
            prio_q <= '0;
        end else begin
            prio_q <= prio_d;
        end
    end
`endif

    // Output register; reset discards any held response.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_val_q   <= 1'b0;
            r_owner_q <= '0;
            r_msg_q   <= '0;
        end else begin
            r_val_q   <= r_val_d;
            r_owner_q <= r_owner_d;
            r_msg_q   <= r_msg_d;
        end
    end

    assign resp0_val = !reset && r_val_q && (r_owner_q == '0);
    assign resp1_val = !reset && r_val_q && (r_owner_q != '0);
    assign resp0_msg = r_msg_q;
    assign resp1_msg = r_msg_q;

endmodule
